cc_psr_stack: RTL and testbench

- Parametrised processor status register holding DATAWIDTH_FLAGS condition flags.
- Adds per-flag write masking and a LIFO shadow stack of depth STACK_DEPTH.
- Trap/interrupt entry pushes the current PSR onto the stack; return pops it back.
- Sits between the ALU flag outputs and the branch/condition logic; replaces the single-level PSR.

---
 rtl/cc_psr_pkg.sv | 21 ++
 rtl/cc_psr_lifo.sv | 75 +++++++
 rtl/cc_psr_stack.sv | 96 +++++++++
 tb/tb_cc_psr_stack.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/cc_psr_pkg.sv
// Shared constants and types for the PSR shadow-stack block.
// Optional macro used by the top: CC_PSRSTACK_LOAD_EN (direct unmasked PSR load port).
package cc_psr_pkg;

    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_V = 1;
    localparam int unsigned FLAG_C = 0;

    localparam int unsigned DEF_DATAWIDTH_FLAGS = 4;
    localparam int unsigned DEF_STACK_DEPTH     = 4;
    localparam int unsigned DEF_DATAWIDTH_COUNT = $clog2(DEF_STACK_DEPTH + 1);

    typedef logic [DEF_DATAWIDTH_FLAGS-1:0] flags_t;

    // Masked flag merge: take new bits where the mask is set, keep old bits elsewhere.
    function automatic flags_t merge_flags(input flags_t old_f, input flags_t new_f, input flags_t mask);
        return (new_f & mask) | (old_f & ~mask);
    endfunction

endpackage

// File: rtl/cc_psr_lifo.sv
// Parametrised register-array LIFO with occupancy count, registered full/empty
// flags and combinational overflow/underflow strobes. Simultaneous push+pop is a no-op.
module cc_psr_lifo
    import cc_psr_pkg::*;
#(
    parameter int unsigned DW    = DEF_DATAWIDTH_FLAGS,
    parameter int unsigned DEPTH = DEF_STACK_DEPTH,
    parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_push,
    input  logic          i_pop,
    input  logic [DW-1:0] i_data,
    output logic [DW-1:0] o_top_c,
    output logic [CW-1:0] o_count,
    output logic          o_full,
    output logic          o_empty,
    output logic          o_ovf_c,
    output logic          o_udf_c
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DW-1:0] r_mem [DEPTH];
    logic [CW-1:0] r_count;
    logic          r_full;
    logic          r_empty;

    logic          w_do_push;
    logic          w_do_pop;
    logic [CW-1:0] w_count_nxt;
    logic [AW-1:0] w_wr_idx;
    logic [AW-1:0] w_rd_idx;

    always_comb begin
        w_do_push   = i_push & ~i_pop & ~r_full;
        w_do_pop    = i_pop & ~i_push & ~r_empty;
        o_ovf_c     = i_push & ~i_pop & r_full;
        o_udf_c     = i_pop & ~i_push & r_empty;
        w_wr_idx    = AW'(r_count);
        // Index 0 while empty keeps the read address in range; the data is unused then.
        w_rd_idx    = r_empty ? '0 : AW'(r_count - CW'(1));
        w_count_nxt = r_count;
        if (w_do_push) begin
            w_count_nxt = r_count + CW'(1);
        end else if (w_do_pop) begin
            w_count_nxt = r_count - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= '0;
            end
            r_count <= '0;
            r_full  <= 1'b0;
            r_empty <= 1'b1;
        end else begin
            if (w_do_push) begin
                r_mem[w_wr_idx] <= i_data;
            end
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == CW'(DEPTH));
            r_empty <= (w_count_nxt == '0);
        end
    end

    assign o_top_c = r_mem[w_rd_idx];
    assign o_count = r_count;
    assign o_full  = r_full;
    assign o_empty = r_empty;

endmodule

// File: rtl/cc_psr_stack.sv
// Processor status register with per-flag write mask and a LIFO shadow stack
// for trap entry/return. Optional macro CC_PSRSTACK_LOAD_EN adds a direct load port.
module cc_psr_stack
    import cc_psr_pkg::*;
#(
    parameter int unsigned DATAWIDTH_FLAGS = DEF_DATAWIDTH_FLAGS,
    parameter int unsigned STACK_DEPTH     = DEF_STACK_DEPTH,
    parameter int unsigned DATAWIDTH_COUNT = $clog2(STACK_DEPTH + 1)
) (
    input  logic                       CC_PSRSTACK_CLOCK_50,
    input  logic                       CC_PSRSTACK_RESET_InLow,
    input  logic [DATAWIDTH_FLAGS-1:0] CC_PSRSTACK_FLAGS_IN,
    input  logic                       CC_PSRSTACK_SETCOND_InHigh,
    input  logic [DATAWIDTH_FLAGS-1:0] CC_PSRSTACK_MASK_IN,
    input  logic                       CC_PSRSTACK_PUSH_InHigh,
    input  logic                       CC_PSRSTACK_POP_InHigh,
`ifdef CC_PSRSTACK_LOAD_EN
    input  logic                       CC_PSRSTACK_LOAD_InHigh,
    input  logic [DATAWIDTH_FLAGS-1:0] CC_PSRSTACK_LOAD_DATA,
`endif
    output logic [DATAWIDTH_FLAGS-1:0] CC_PSRSTACK_PSR_OUT,
    output logic [DATAWIDTH_COUNT-1:0] CC_PSRSTACK_COUNT_OUT,
    output logic                       CC_PSRSTACK_FULL_OUT,
    output logic                       CC_PSRSTACK_EMPTY_OUT,
    output logic                       CC_PSRSTACK_ERR_OUT
);

    logic [DATAWIDTH_FLAGS-1:0] r_psr;
    logic                       r_err;

    logic [DATAWIDTH_FLAGS-1:0] w_psr_nxt;
    logic [DATAWIDTH_FLAGS-1:0] w_psr_upd;
    logic                       w_err_nxt;
    logic                       w_pop_only;
    logic [DATAWIDTH_FLAGS-1:0] w_top;
    logic                       w_full;
    logic                       w_empty;
    logic                       w_ovf;
    logic                       w_udf;
    logic [DATAWIDTH_COUNT-1:0] w_count;

    // The stack always saves the pre-update PSR; push+pop resolution lives in the LIFO.
    cc_psr_lifo #(
        .DW    (DATAWIDTH_FLAGS),
        .DEPTH (STACK_DEPTH),
        .CW    (DATAWIDTH_COUNT)
    ) u_lifo (
        .clk     (CC_PSRSTACK_CLOCK_50),
        .rst_n   (CC_PSRSTACK_RESET_InLow),
        .i_push  (CC_PSRSTACK_PUSH_InHigh),
        .i_pop   (CC_PSRSTACK_POP_InHigh),
        .i_data  (r_psr),
        .o_top_c (w_top),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_ovf_c (w_ovf),
        .o_udf_c (w_udf)
    );

    // Next-state: pop (restore or underflow hold) beats load beats masked setcond.
    always_comb begin
        w_pop_only = CC_PSRSTACK_POP_InHigh & ~CC_PSRSTACK_PUSH_InHigh;
        w_psr_upd  = r_psr;
        if (CC_PSRSTACK_SETCOND_InHigh) begin
            w_psr_upd = (CC_PSRSTACK_FLAGS_IN & CC_PSRSTACK_MASK_IN) | (r_psr & ~CC_PSRSTACK_MASK_IN);
        end
`ifdef CC_PSRSTACK_LOAD_EN
        if (CC_PSRSTACK_LOAD_InHigh) begin
            w_psr_upd = CC_PSRSTACK_LOAD_DATA;
        end
`endif
        w_psr_nxt = w_psr_upd;
        if (w_pop_only) begin
            w_psr_nxt = w_empty ? r_psr : w_top;
        end
        w_err_nxt = r_err | w_ovf | w_udf;
    end

    always_ff @(posedge CC_PSRSTACK_CLOCK_50 or negedge CC_PSRSTACK_RESET_InLow) begin
        if (!CC_PSRSTACK_RESET_InLow) begin
            r_psr <= '0;
            r_err <= 1'b0;
        end else begin
            r_psr <= w_psr_nxt;
            r_err <= w_err_nxt;
        end
    end

    assign CC_PSRSTACK_PSR_OUT   = r_psr;
    assign CC_PSRSTACK_COUNT_OUT = w_count;
    assign CC_PSRSTACK_FULL_OUT  = w_full;
    assign CC_PSRSTACK_EMPTY_OUT = w_empty;
    assign CC_PSRSTACK_ERR_OUT   = r_err;

endmodule

// File: tb/tb_cc_psr_stack.sv
// Self-checking bench for cc_psr_stack: directed test-plan sequence followed by
// randomized traffic, all checked against a queue-based reference model.
module tb_cc_psr_stack;

    localparam int unsigned W     = 4;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst_n;
    logic [W-1:0]  flags;
    logic [W-1:0]  mask;
    logic          setc;
    logic          push;
    logic          pop;
    logic [W-1:0]  psr;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;
    logic          err;
`ifdef CC_PSRSTACK_LOAD_EN
    logic          load  = 1'b0;
    logic [W-1:0]  ldata = '0;
`endif

    // Reference model
    logic [W-1:0]  m_psr;
    logic [W-1:0]  m_q[$];
    logic          m_err;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    cc_psr_stack #(
        .DATAWIDTH_FLAGS (W),
        .STACK_DEPTH     (DEPTH),
        .DATAWIDTH_COUNT (CW)
    ) dut (
        .CC_PSRSTACK_CLOCK_50       (clk),
        .CC_PSRSTACK_RESET_InLow    (rst_n),
        .CC_PSRSTACK_FLAGS_IN       (flags),
        .CC_PSRSTACK_SETCOND_InHigh (setc),
        .CC_PSRSTACK_MASK_IN        (mask),
        .CC_PSRSTACK_PUSH_InHigh    (push),
        .CC_PSRSTACK_POP_InHigh     (pop),
`ifdef CC_PSRSTACK_LOAD_EN
        .CC_PSRSTACK_LOAD_InHigh    (load),
        .CC_PSRSTACK_LOAD_DATA      (ldata),
`endif
        .CC_PSRSTACK_PSR_OUT        (psr),
        .CC_PSRSTACK_COUNT_OUT      (count),
        .CC_PSRSTACK_FULL_OUT       (full),
        .CC_PSRSTACK_EMPTY_OUT      (empty),
        .CC_PSRSTACK_ERR_OUT        (err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".psr"},   32'(psr),   32'(m_psr));
        chk({tag, ".count"}, 32'(count), 32'(m_q.size()));
        chk({tag, ".full"},  32'(full),  32'(m_q.size() == DEPTH));
        chk({tag, ".empty"}, 32'(empty), 32'(m_q.size() == 0));
        chk({tag, ".err"},   32'(err),   32'(m_err));
    endtask

    task automatic model_step();
        logic [W-1:0] nxt;
        if (pop && !push) begin
            if (m_q.size() > 0) m_psr = m_q.pop_back();
            else                m_err = 1'b1;
        end else begin
            nxt = m_psr;
            for (int i = 0; i < int'(W); i++) begin
                if (setc && mask[i]) nxt[i] = flags[i];
            end
            if (push && !pop) begin
                if (m_q.size() < DEPTH) m_q.push_back(m_psr);
                else                    m_err = 1'b1;
            end
            m_psr = nxt;
        end
    endtask

    task automatic cycle(input string tag, input logic [W-1:0] f, input logic [W-1:0] m,
                         input logic s, input logic pu, input logic po);
        flags = f; mask = m; setc = s; push = pu; pop = po;
        model_step();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst_n = 1'b0;
        m_psr = '0; m_q.delete(); m_err = 1'b0;
        #1;
        check_all({tag, ".async"});
        @(posedge clk);
        #1;
        check_all({tag, ".held"});
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        flags = '0; mask = '0; setc = 1'b0; push = 1'b0; pop = 1'b0;
        m_psr = '0; m_q.delete(); m_err = 1'b0;
        #12;
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;

        cycle("set_all",  4'b1010, 4'b1111, 1'b1, 1'b0, 1'b0);
        chk("plan.psr1010", 32'(psr), 32'hA);
        cycle("set_mask", 4'b0101, 4'b0011, 1'b1, 1'b0, 1'b0);
        chk("plan.psr1001", 32'(psr), 32'h9);
        cycle("push_set", 4'b0000, 4'b1111, 1'b1, 1'b1, 1'b0);
        chk("plan.push_cnt1", 32'(count), 32'd1);
        cycle("pop1",     4'b1111, 4'b1111, 1'b1, 1'b0, 1'b1);
        chk("plan.pop_psr", 32'(psr), 32'h9);

        // Fill with distinct values, then overflow, drain in LIFO order, underflow.
        for (int i = 0; i < int'(DEPTH); i++) begin
            cycle("fill", W'(i + 3), 4'b1111, 1'b1, 1'b1, 1'b0);
        end
        chk("plan.full", 32'(full), 32'd1);
        cycle("overflow", 4'b0110, 4'b1111, 1'b1, 1'b1, 1'b0);
        chk("plan.ovf_err", 32'(err), 32'd1);
        for (int i = 0; i < int'(DEPTH); i++) begin
            cycle("drain", 4'b0000, 4'b1111, 1'b1, 1'b0, 1'b1);
        end
        cycle("underflow", 4'b1111, 4'b1111, 1'b1, 1'b0, 1'b1);
        chk("plan.udf_err", 32'(err), 32'd1);

        do_reset("rst1");
        cycle("pre2a", 4'b0001, 4'b1111, 1'b1, 1'b1, 1'b0);
        cycle("pre2b", 4'b0010, 4'b1111, 1'b1, 1'b1, 1'b0);
        cycle("pushpop", 4'b1100, 4'b0110, 1'b1, 1'b1, 1'b1);
        chk("plan.pp_cnt", 32'(count), 32'd2);
        chk("plan.pp_err", 32'(err), 32'd0);
        cycle("pre3", 4'b0111, 4'b1111, 1'b1, 1'b1, 1'b0);

        // Asynchronous reset mid-cycle, checked before any further clock edge.
        #3;
        rst_n = 1'b0;
        m_psr = '0; m_q.delete(); m_err = 1'b0;
        #1;
        check_all("async_rst");
        @(negedge clk);
        rst_n = 1'b1;

        for (int n = 0; n < 600; n++) begin
            logic [W-1:0] rf, rm;
            logic rs, rpu, rpo;
            rf  = W'($urandom);
            rm  = W'($urandom);
            rs  = ($urandom_range(0, 3) != 0);
            rpu = ($urandom_range(0, 9) < 4);
            rpo = ($urandom_range(0, 9) < 4);
            cycle("rand", rf, rm, rs, rpu, rpo);
            if (n == 300) do_reset("rst_rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
